// File: rtl/serial_adder_n_if.sv
// Request/result bundle for serial_adder_n.
// The master drives the operands and start strobe; the slave returns busy/done and the result.
interface serial_adder_n_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;

    modport master (
        output start, sub, a, b, ci,
        input  busy, done, s, co, ovf
    );

    modport slave (
        input  start, sub, a, b, ci,
        output busy, done, s, co, ovf
    );
endinterface

// File: rtl/serial_adder_n.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands are consumed DIGIT bits per clock
// through a single DIGIT-bit adder slice, with a one-cycle done strobe at completion.
module serial_adder_n #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input logic           clk,
    input logic           rst,
    serial_adder_n_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             msbA_q, msbA_d;
    logic             msbB_q, msbB_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [DIGIT:0]         slice;
    logic [WIDTH+DIGIT-1:0] resCat;
    logic [WIDTH-1:0]       resShift;
    logic                   accept;

    // Digit slice, result shift and next-state selection for the IDLE/RUN/DONE sequencer.
    always_comb begin
        slice    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
        resCat   = {slice[DIGIT-1:0], res_q};
        resShift = resCat[WIDTH+DIGIT-1:DIGIT];
        accept   = bus.start && ((state_q == IDLE) || (state_q == DONE));

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        msbA_d  = msbA_q;
        msbB_d  = msbB_q;
        s_d     = s_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    a_d     = bus.a;
                    b_d     = bus.b ^ {WIDTH{bus.sub}};
                    carry_d = bus.ci ^ bus.sub;
                    msbA_d  = bus.a[WIDTH-1];
                    msbB_d  = bus.b[WIDTH-1] ^ bus.sub;
                    res_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = slice[DIGIT];
                res_d   = resShift;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    s_d     = resShift;
                    co_d    = slice[DIGIT];
                    ovf_d   = (msbA_q == msbB_q) && (resShift[WIDTH-1] != msbA_q);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
            msbA_q  <= 1'b0;
            msbB_q  <= 1'b0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            msbA_q  <= msbA_d;
            msbB_q  <= msbB_d;
            s_q     <= s_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.s    = s_q;
    assign bus.co   = co_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder_n.sv
// Bench for serial_adder_n: an 8-bit/1-bit-digit and a 16-bit/4-bit-digit instance
// checked against an integer-arithmetic reference model.
module tb_serial_adder_n;
    logic clk = 1'b0;
    logic rst;
    int   checkCount = 0;
    int   errorCount = 0;

    always #5 clk = ~clk;

    serial_adder_n_if #(.WIDTH(8))  bus8 ();
    serial_adder_n_if #(.WIDTH(16)) bus16 ();

    serial_adder_n #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    serial_adder_n #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference: exact integer add/subtract, unsigned for carry, signed for overflow.
    task automatic refModel(input int w, input logic [15:0] a, input logic [15:0] b,
                            input logic ci, input logic sub,
                            output logic [15:0] s, output logic co, output logic ovf);
        longint one = 1;
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = a[w-1] ? ua - (one << w) : ua;
        longint sb = b[w-1] ? ub - (one << w) : ub;
        longint r;
        longint sr;
        if (!sub) begin
            r  = ua + ub + longint'(ci);
            sr = sa + sb + longint'(ci);
            co = ((r >> w) & one) != 0;
        end else begin
            r  = ua - ub - longint'(ci);
            sr = sa - sb - longint'(ci);
            co = (r >= 0);
        end
        s   = 16'(r & ((one << w) - one));
        ovf = (sr > (one << (w - 1)) - one) || (sr < -(one << (w - 1)));
    endtask

    function automatic logic getDone(input int which);
        return (which != 0) ? bus16.done : bus8.done;
    endfunction

    function automatic logic getBusy(input int which);
        return (which != 0) ? bus16.busy : bus8.busy;
    endfunction

    function automatic logic [15:0] getS(input int which);
        return (which != 0) ? bus16.s : {8'h00, bus8.s};
    endfunction

    function automatic logic getCo(input int which);
        return (which != 0) ? bus16.co : bus8.co;
    endfunction

    function automatic logic getOvf(input int which);
        return (which != 0) ? bus16.ovf : bus8.ovf;
    endfunction

    // One full operation on the chosen instance, with latency, busy length and result checks.
    task automatic applyStimulus(input int which, input logic [15:0] a, input logic [15:0] b,
                                 input logic ci, input logic sub, input string label);
        int          w       = (which != 0) ? 16 : 8;
        int          expLat  = (which != 0) ? 4 : 8;
        int          latency = 0;
        int          busyCycles = 0;
        logic [15:0] expS;
        logic        expCo;
        logic        expOvf;
        refModel(w, a, b, ci, sub, expS, expCo, expOvf);
        @(negedge clk);
        if (which != 0) begin
            bus16.start = 1'b1; bus16.a = a; bus16.b = b; bus16.ci = ci; bus16.sub = sub;
        end else begin
            bus8.start = 1'b1; bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.ci = ci; bus8.sub = sub;
        end
        @(posedge clk); #1;
        bus8.start  = 1'b0;
        bus16.start = 1'b0;
        while (!getDone(which) && latency < 60) begin
            if (getBusy(which)) busyCycles++;
            @(posedge clk); #1;
            latency++;
        end
        checkOutput({label, " latency"}, latency, expLat);
        checkOutput({label, " busy cycles"}, busyCycles, expLat);
        checkOutput({label, " busy at done"}, 32'(getBusy(which)), 0);
        checkOutput({label, " s"}, 32'(getS(which)), 32'(expS));
        checkOutput({label, " co"}, 32'(getCo(which)), 32'(expCo));
        checkOutput({label, " ovf"}, 32'(getOvf(which)), 32'(expOvf));
        @(posedge clk); #1;
        checkOutput({label, " done drop"}, 32'(getDone(which)), 0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          n;
        int          m;
        int          sawDone;
        logic        heldOk;
        logic [15:0] ra;
        logic [15:0] rb;

        rst = 1'b1;
        bus8.start = 1'b0;  bus8.sub = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.ci = 1'b0;
        bus16.start = 1'b0; bus16.sub = 1'b0; bus16.a = '0; bus16.b = '0; bus16.ci = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus8.start = 1'($urandom); bus8.a = 8'($urandom); bus8.b = 8'($urandom);
            bus8.ci = 1'($urandom); bus8.sub = 1'($urandom);
            bus16.start = 1'($urandom); bus16.a = 16'($urandom); bus16.b = 16'($urandom);
        end
        #1;
        checkOutput("reset busy", 32'(bus8.busy), 0);
        checkOutput("reset done", 32'(bus8.done), 0);
        checkOutput("reset s", 32'(bus8.s), 0);
        checkOutput("reset co", 32'(bus8.co), 0);
        checkOutput("reset ovf", 32'(bus8.ovf), 0);
        checkOutput("reset16 s", 32'(bus16.s), 0);
        checkOutput("reset16 busy", 32'(bus16.busy), 0);
        @(negedge clk);
        rst = 1'b0;
        bus8.start = 1'b0;
        bus16.start = 1'b0;

        applyStimulus(0, 16'h005A, 16'h003C, 1'b0, 1'b0, "add ovf");
        applyStimulus(0, 16'h00FF, 16'h0001, 1'b1, 1'b0, "carry chain");
        applyStimulus(0, 16'h0010, 16'h0020, 1'b0, 1'b1, "sub borrow");
        applyStimulus(0, 16'h0080, 16'h0001, 1'b0, 1'b1, "sub ovf");
        applyStimulus(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, "digit4 ovf");
        applyStimulus(1, 16'h0000, 16'h0001, 1'b1, 1'b1, "digit4 sub");

        // Abort after three digits: no done, outputs cleared.
        applyStimulus(0, 16'h005A, 16'h003C, 1'b0, 1'b0, "pre abort");
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'h01; bus8.b = 8'h01; bus8.ci = 1'b0; bus8.sub = 1'b0;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        checkOutput("abort s", 32'(bus8.s), 0);
        checkOutput("abort busy", 32'(bus8.busy), 0);
        checkOutput("abort co", 32'(bus8.co), 0);
        checkOutput("abort ovf", 32'(bus8.ovf), 0);
        @(negedge clk);
        rst = 1'b0;
        sawDone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus8.done || bus8.busy) sawDone++;
        end
        checkOutput("abort no done", sawDone, 0);

        // Start held through RUN, then back-to-back restart from DONE.
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'h11; bus8.b = 8'h22; bus8.ci = 1'b0; bus8.sub = 1'b0;
        @(posedge clk); #1;
        n = 0;
        while (!bus8.done && n < 40) begin
            bus8.a = 8'($urandom);
            bus8.b = 8'($urandom);
            @(posedge clk); #1;
            n++;
        end
        checkOutput("hold latency", n, 8);
        checkOutput("hold s", 32'(bus8.s), 32'h33);
        bus8.a = 8'h01;
        bus8.b = 8'h02;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        checkOutput("b2b done drop", 32'(bus8.done), 0);
        checkOutput("b2b busy", 32'(bus8.busy), 1);
        m = 1;
        heldOk = 1'b1;
        while (!bus8.done && m < 40) begin
            if (bus8.s !== 8'h33) heldOk = 1'b0;
            @(posedge clk); #1;
            m++;
        end
        checkOutput("b2b gap", m, 9);
        checkOutput("b2b s held", 32'(heldOk), 1);
        checkOutput("b2b s", 32'(bus8.s), 32'h03);

        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom_range(0, 255));
            rb = 16'($urandom_range(0, 255));
            applyStimulus(0, ra, rb, 1'($urandom), 1'($urandom), "rand8");
        end
        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            applyStimulus(1, ra, rb, 1'($urandom), 1'($urandom), "rand16");
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
